// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit bus CPU: control-word bit positions, opcodes and T-states.
package cpu_pkg;

  typedef logic [15:0] ctrl_word_t;

  localparam int unsigned AI  = 0;
  localparam int unsigned AO  = 1;
  localparam int unsigned II  = 2;
  localparam int unsigned IO  = 3;
  localparam int unsigned IIO = 4;
  localparam int unsigned OI  = 5;
  localparam int unsigned OO  = 6;
  localparam int unsigned MI  = 7;
  localparam int unsigned MO  = 8;
  localparam int unsigned BI  = 9;
  localparam int unsigned EO  = 10;
  localparam int unsigned SU  = 11;
  localparam int unsigned FI  = 12;
  localparam int unsigned PCE = 13;
  localparam int unsigned PCO = 14;
  localparam int unsigned PCI = 15;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] STAGE_T0 = 3'd0;
  localparam logic [2:0] STAGE_T1 = 3'd1;
  localparam logic [2:0] STAGE_T2 = 3'd2;
  localparam logic [2:0] STAGE_T3 = 3'd3;
  localparam logic [2:0] STAGE_T4 = 3'd4;

endpackage

// File: rtl/ctrl_ucode_rom.sv
// Combinational microcode lookup: {opcode, stage, c, z} -> {ctrl, last_step, bad_op}.
// CTRL_SEQ_EARLY_END_EN: flag the current step as last when the following microword is empty.
module ctrl_ucode_rom
  import cpu_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [2:0]  i_stage,
  input  logic        i_flag_c,
  input  logic        i_flag_z,
  output logic [15:0] o_ctrl,
  output logic        o_last_step,
  output logic        o_bad_op
);

  function automatic ctrl_word_t ucode(input logic [3:0] op, input logic [2:0] st,
                                       input logic c, input logic z);
    ctrl_word_t w;
    w = '0;
    case (st)
      STAGE_T0: begin
        w[PCO] = 1'b1;
        w[MI]  = 1'b1;
      end
      STAGE_T1: begin
        w[MO]  = 1'b1;
        w[II]  = 1'b1;
        w[PCE] = 1'b1;
      end
      STAGE_T2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB: begin
            w[IO] = 1'b1; w[IIO] = 1'b1; w[MI] = 1'b1;
          end
          OP_LDI: begin
            w[IO] = 1'b1; w[IIO] = 1'b1; w[AI] = 1'b1;
          end
          OP_JMP: begin
            w[IO] = 1'b1; w[IIO] = 1'b1; w[PCI] = 1'b1;
          end
          OP_JC: begin
            w[IO] = c; w[IIO] = c; w[PCI] = c;
          end
          OP_JZ: begin
            w[IO] = z; w[IIO] = z; w[PCI] = z;
          end
          OP_OUT: begin
            w[AO] = 1'b1; w[OI] = 1'b1;
          end
          default: ;
        endcase
      end
      STAGE_T3: begin
        case (op)
          OP_LDA: begin
            w[MO] = 1'b1; w[AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w[MO] = 1'b1; w[BI] = 1'b1;
          end
          default: ;
        endcase
      end
      STAGE_T4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          w[EO] = 1'b1; w[AI] = 1'b1; w[FI] = 1'b1;
          w[SU] = (op == OP_SUB);
        end
      end
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic op_defined(input logic [3:0] op);
    case (op)
      OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_LDI, OP_JMP,
      OP_JC, OP_JZ, OP_OUT, OP_HLT: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  always_comb begin
    o_ctrl      = ucode(i_opcode, i_stage, i_flag_c, i_flag_z);
    o_bad_op    = (i_stage == STAGE_T2) && !op_defined(i_opcode);
    o_last_step = (i_stage >= STAGE_T4);
`ifdef CTRL_SEQ_EARLY_END_EN
    // Opcode is only trustworthy from T2, so T0/T1 never terminate early.
    if (i_stage >= STAGE_T2 && i_stage < STAGE_T4) begin
      o_last_step = (ucode(i_opcode, i_stage + 3'd1, i_flag_c, i_flag_z) == '0);
    end
`endif
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// T-state counter, halt latch and control-word gating for the bus CPU.
// Early termination of empty steps is enabled by defining CTRL_SEQ_EARLY_END_EN.
module ctrl_sequencer
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_opcode,
  input  logic        i_flag_c,
  input  logic        i_flag_z,
  output logic [15:0] o_ctrl,
  output logic [2:0]  o_stage,
  output logic        o_halted,
  output logic        o_bad_op
);

  logic [2:0]  stage_q, stage_d;
  logic        halted_q, halted_d;
  logic [15:0] rom_ctrl;
  logic        rom_last;
  logic        rom_bad;

  ctrl_ucode_rom u_rom (
    .i_opcode    (i_opcode),
    .i_stage     (stage_q),
    .i_flag_c    (i_flag_c),
    .i_flag_z    (i_flag_z),
    .o_ctrl      (rom_ctrl),
    .o_last_step (rom_last),
    .o_bad_op    (rom_bad)
  );

  always_comb begin
    stage_d  = stage_q;
    halted_d = halted_q;
    if (halted_q) begin
      stage_d = STAGE_T0;
    end else if (stage_q == STAGE_T2 && i_opcode == OP_HLT) begin
      halted_d = 1'b1;
      stage_d  = STAGE_T0;
    end else if (rom_last) begin
      stage_d = STAGE_T0;
    end else begin
      stage_d = stage_q + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stage_q  <= STAGE_T0;
      halted_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      halted_q <= halted_d;
    end
  end

  // Gate with the raw reset so an abort drops every strobe in the same cycle.
  always_comb begin
    o_ctrl   = (halted_q || !i_rst) ? 16'h0000 : rom_ctrl;
    o_bad_op = rom_bad && !halted_q && i_rst;
    o_stage  = stage_q;
    o_halted = halted_q;
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with a per-cycle expected-value scoreboard.
module tb_ctrl_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [3:0]  i_opcode = 4'h0;
  logic        i_flag_c = 1'b0;
  logic        i_flag_z = 1'b0;
  logic [15:0] o_ctrl;
  logic [2:0]  o_stage;
  logic        o_halted;
  logic        o_bad_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [2:0]  stage;
    logic [15:0] ctrl;
    logic        halted;
    logic        bad;
  } exp_t;

  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  ctrl_sequencer dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_opcode (i_opcode),
    .i_flag_c (i_flag_c),
    .i_flag_z (i_flag_z),
    .o_ctrl   (o_ctrl),
    .o_stage  (o_stage),
    .o_halted (o_halted),
    .o_bad_op (o_bad_op)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_word(input logic [3:0] op, input int s,
                                           input logic c, input logic z);
    case (s)
      0: return 16'h4080;
      1: return 16'h2104;
      2: case (op)
           4'b0001, 4'b0010, 4'b0011: return 16'h0098;
           4'b0101: return 16'h0019;
           4'b0110: return 16'h8018;
           4'b0111: return c ? 16'h8018 : 16'h0000;
           4'b1000: return z ? 16'h8018 : 16'h0000;
           4'b1110: return 16'h0022;
           default: return 16'h0000;
         endcase
      3: case (op)
           4'b0001: return 16'h0101;
           4'b0010, 4'b0011: return 16'h0300;
           default: return 16'h0000;
         endcase
      4: case (op)
           4'b0010: return 16'h1401;
           4'b0011: return 16'h1C01;
           default: return 16'h0000;
         endcase
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int exp_len(input logic [3:0] op);
`ifdef CTRL_SEQ_EARLY_END_EN
    case (op)
      4'b0001:          return 4;
      4'b0010, 4'b0011: return 5;
      default:          return 3;
    endcase
`else
    return (op == 4'b0000) ? 5 : 5;
`endif
  endfunction

  function automatic logic is_undef(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1110, 4'b1111: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic push_exp(input string tag, input logic [2:0] stage, input logic [15:0] ctrl,
                          input logic halted, input logic bad);
    exp_t e;
    e.tag = tag; e.stage = stage; e.ctrl = ctrl; e.halted = halted; e.bad = bad;
    sb.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed no entry, required one");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (o_ctrl === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed %h expected %h", e.tag, o_ctrl, e.ctrl);
    end
    checks++;
    assert (o_stage === e.stage) else begin
      errors++;
      $error("FAIL %s stage observed %0d expected %0d", e.tag, o_stage, e.stage);
    end
    checks++;
    assert (o_halted === e.halted) else begin
      errors++;
      $error("FAIL %s halted observed %b expected %b", e.tag, o_halted, e.halted);
    end
    checks++;
    assert (o_bad_op === e.bad) else begin
      errors++;
      $error("FAIL %s bad_op observed %b expected %b", e.tag, o_bad_op, e.bad);
    end
  endtask

  // Entered and left at posedge+1; inputs driven, then checked at negedge.
  task automatic cycle(input string tag, input logic [3:0] op, input logic c, input logic z,
                       input logic [2:0] stage, input logic [15:0] ctrl,
                       input logic halted, input logic bad);
    i_opcode = op;
    i_flag_c = c;
    i_flag_z = z;
    push_exp(tag, stage, ctrl, halted, bad);
    @(negedge i_clk);
    compare_now();
    @(posedge i_clk);
    #1;
  endtask

  // Flags are inverted in fetch so only the T2 value can steer a jump.
  task automatic run_op(input string tag, input logic [3:0] op, input logic c, input logic z);
    int n;
    n = exp_len(op);
    for (int s = 0; s < n; s++) begin
      cycle(tag, op, (s < 2) ? ~c : c, (s < 2) ? ~z : z, 3'(s), exp_word(op, s, c, z),
            1'b0, (s == 2) && is_undef(op));
    end
  endtask

  initial begin
    // Reset held: everything zero regardless of inputs.
    i_opcode = 4'b0010;
    #12;
    push_exp("reset", 3'd0, 16'h0000, 1'b0, 1'b0);
    compare_now();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;

    run_op("nop",  4'b0000, 1'b0, 1'b0);
    run_op("ldi",  4'b0101, 1'b0, 1'b0);
    run_op("lda",  4'b0001, 1'b0, 1'b0);
    run_op("add",  4'b0010, 1'b0, 1'b0);
    run_op("sub",  4'b0011, 1'b1, 1'b1);
    run_op("jmp",  4'b0110, 1'b0, 1'b0);
    run_op("jc1",  4'b0111, 1'b1, 1'b0);
    run_op("jc0",  4'b0111, 1'b0, 1'b1);
    run_op("jz1",  4'b1000, 1'b0, 1'b1);
    run_op("jz0",  4'b1000, 1'b1, 1'b0);
    run_op("out",  4'b1110, 1'b0, 1'b0);
    run_op("bad",  4'b1010, 1'b0, 1'b0);
    run_op("bad2", 4'b1100, 1'b1, 1'b1);

    // Reset asserted in T3 of ADD aborts immediately.
    cycle("abort", 4'b0010, 1'b0, 1'b0, 3'd0, 16'h4080, 1'b0, 1'b0);
    cycle("abort", 4'b0010, 1'b0, 1'b0, 3'd1, 16'h2104, 1'b0, 1'b0);
    cycle("abort", 4'b0010, 1'b0, 1'b0, 3'd2, 16'h0098, 1'b0, 1'b0);
    #2;
    push_exp("abort_t3", 3'd3, 16'h0300, 1'b0, 1'b0);
    compare_now();
    i_rst = 1'b0;
    #1;
    push_exp("abort_rst", 3'd0, 16'h0000, 1'b0, 1'b0);
    compare_now();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    run_op("post_abort", 4'b0000, 1'b0, 1'b0);

    // HLT: halted rises on the edge ending T2, then everything holds.
    cycle("hlt", 4'b1111, 1'b0, 1'b0, 3'd0, 16'h4080, 1'b0, 1'b0);
    cycle("hlt", 4'b1111, 1'b0, 1'b0, 3'd1, 16'h2104, 1'b0, 1'b0);
    cycle("hlt", 4'b1111, 1'b0, 1'b0, 3'd2, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle("hlt_hold", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 3'd0, 16'h0000, 1'b1, 1'b0);
    end
    i_rst = 1'b0;
    #2;
    push_exp("hlt_rst", 3'd0, 16'h0000, 1'b0, 1'b0);
    compare_now();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    run_op("restart_nop", 4'b0000, 1'b0, 1'b0);
    run_op("restart_add", 4'b0010, 1'b0, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
